red_pitaya_zc_phase_meter: RTL and testbench
============================================

Name: red_pitaya_zc_phase_meter

Overview:
Downstream measurement stage for the ASG channel A output. Compares zero crossings of the generated DAC code against the returned ADC signal, and accumulates the period and the ref-to-signal delay over N periods so software can compute frequency and phase. Sits beside the ASG on dac_clk_i. Takes dac_a_o as reference and adc_a_i or adc_b_i as signal. Results and status are exported to the ASG register map.

Parameters:
DW, 14, sample width (signed two's complement) of ref and signal
CW, 32, width of accumulators and timeout counter
NW, 8, width of period-count input
HYST, 16, hysteresis magnitude in LSBs (used only with the optional feature)

Ports:
dac_clk_i  in  1  clock
dac_rstn_i  in  1  reset; synchronous, active-low
ref_i  in  DW  reference samples (DAC code), signed
sig_i  in  DW  measured samples (ADC code), signed
start_i  in  1  single-cycle start pulse
navg_i  in  NW  number of periods to accumulate; 0 treated as 1
timeout_i  in  CW  maximum cycles between ref crossings; 0 disables
busy_o  out  1  measurement in progress
done_o  out  1  single-cycle completion pulse
tout_o  out  1  last measurement ended by timeout (held until next start)
miss_o  out  1  at least one period had no signal crossing (held until next start)
period_sum_o  out  CW  cycles spanned by navg periods
delay_sum_o  out  CW  summed ref-to-signal crossing delays
state_o  out  3  FSM state, for debug/register readout

Behaviour:
- Reset: everything is synchronous to dac_clk_i and sampled while dac_rstn_i=0. Every output goes to 0, FSM to IDLE, arm flags cleared. Reset mid-measurement aborts with no done_o.
- Crossing detector, one per input:
  - Arm when sample < 0. A rising event fires when armed and sample >= 0; the arm flag clears on the event.
  - Event flag is registered: a sample entering at cycle t gives ev at t+1.
  - Detectors run continuously in every state.
- FSM encoding: IDLE=0, SYNC=1, MEAS=2, DONE=3, TOUT=4.
  - IDLE: start_i -> SYNC. On this transition clear accumulators, tout_o and miss_o, latch navg (0->1) and timeout_i, set busy_o=1. start_i in any other state is ignored.
  - SYNC: wait for the first ref event, discarding the partial period. On ref event -> MEAS; per-period counter pcnt=1, delay pending.
  - MEAS, every cycle: pcnt increments; while delay pending, dcnt increments.
    - sig event while pending: delay_sum += dcnt; pending clears.
    - ref event (end of period): period_sum += pcnt.
      - If still pending: delay_sum += pcnt and miss_o=1.
      - Then pcnt=1, dcnt=0, pending=1, and the period counter increments.
      - If the period counter reaches the latched navg -> DONE.
    - sig and ref events in the same cycle: the sig event belongs to the new period (delay 0). The previous period is closed first as missing if it was pending.
  - DONE: done_o=1 for exactly one cycle; period_sum_o/delay_sum_o updated in the same cycle; busy_o=0; next cycle -> IDLE. Latency is 1 cycle from the final ref event to done_o.
  - Timeout: in SYNC or MEAS, a cycles-since-last-ref-event counter reaching the latched nonzero timeout -> TOUT.
  - TOUT: done_o=1 and tout_o=1 for that cycle; period_sum_o=delay_sum_o=0; busy_o=0; -> IDLE.
- Arithmetic: all accumulators and counters are unsigned CW bits and saturate at all-ones; no wrap.
- Outputs hold their values until the next DONE/TOUT or reset.

Optional Feature:
- Macro: ZC_PHASE_HYST_EN.
- Defined: a detector arms only when sample < -HYST and fires when armed and sample >= +HYST. This rejects noise chatter around zero.
- Undefined: plain sign detection as described above; HYST is unused.
- Event latency (1 cycle) and the FSM are identical in both builds.

Test Plan:
- Square waves ±4000, period 100 cycles, sig lagging ref by 25 cycles, navg=4, start -> done_o once; period_sum_o=400, delay_sum_o=100, miss_o=0, tout_o=0.
- Same stimulus with sig lagging 0 cycles (coincident crossings), navg=2 -> period_sum_o=200, delay_sum_o=0.
- ref period 100, sig held at +100 (no crossings), navg=3 -> period_sum_o=300, delay_sum_o=300, miss_o=1.
- ref held at -500, timeout_i=1000, start -> 1000 cycles later done_o with tout_o=1, sums=0; busy_o low the next cycle.
- navg_i=0, period 50 -> behaves as navg=1: period_sum_o=50. start_i pulsed again mid-measurement -> ignored. dac_rstn_i low mid-MEAS -> all outputs 0, no done_o, state_o=0.
- With ZC_PHASE_HYST_EN and HYST=16: ref sine amplitude 2000 plus ±10 LSB noise at zero crossing, period 200, navg=8 -> period_sum_o=1600 with no spurious events. Without the macro, the same noise case shows extra events (period_sum_o < 1600).

Source files
------------

// File: rtl/red_pitaya_zc_phase_meter.sv
// -----------------------------------------------------------------------------
// red_pitaya_zc_phase_meter
//
// Zero-crossing frequency/phase meter for the ASG channel A output. The DAC
// code is the reference, a returned ADC channel is the signal. After a start
// pulse the block syncs to the next reference rising crossing, then sums the
// length of navg reference periods and the ref-to-signal crossing delay of
// each period. Software derives frequency and phase from the two sums.
//
// Optional build macro: ZC_PHASE_HYST_EN
//   defined   : detectors arm below -HYST and fire at or above +HYST
//   undefined : plain sign detection, HYST unused
//
// Ports:
//   dac_clk_i, dac_rstn_i   clock, synchronous active-low reset
//   ref_i, sig_i            signed DW-bit reference / signal samples
//   start_i                 single-cycle start pulse (honoured in IDLE only)
//   navg_i                  periods to accumulate (0 behaves as 1)
//   timeout_i               max cycles between ref crossings (0 = disabled)
//   busy_o                  measurement in progress
//   done_o                  single-cycle completion pulse (normal or timeout)
//   tout_o, miss_o          sticky status, cleared by the next start
//   period_sum_o            cycles spanned by navg periods
//   delay_sum_o             summed ref-to-signal delays
//   state_o                 FSM state: IDLE=0 SYNC=1 MEAS=2 DONE=3 TOUT=4
// -----------------------------------------------------------------------------

// Rising zero-crossing detector with optional hysteresis band. The event is
// registered: a sample presented in cycle t yields ev_o in cycle t+1.
module red_pitaya_zc_det #(
  parameter int DW  = 14,
  parameter int LVL = 0
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] smp_i,
  output logic          ev_o
);
  localparam logic signed [DW:0] LVL_P = (DW+1)'(LVL);
  localparam logic signed [DW:0] LVL_N = (DW+1)'(-LVL);

  logic signed [DW:0] smp;
  logic below, above;
  logic arm_q, arm_d, ev_q, ev_d;

  always_comb begin
    smp   = {smp_i[DW-1], smp_i};
    below = smp < LVL_N;
    above = smp >= LVL_P;
    ev_d  = arm_q & above;
    // Firing disarms; a sample inside the band keeps the current arm state.
    arm_d = below | (arm_q & ~above);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      arm_q <= 1'b0;
      ev_q  <= 1'b0;
    end else begin
      arm_q <= arm_d;
      ev_q  <= ev_d;
    end
  end

  assign ev_o = ev_q;
endmodule

module red_pitaya_zc_phase_meter #(
  parameter int DW   = 14,
  parameter int CW   = 32,
  parameter int NW   = 8,
  parameter int HYST = 16
) (
  input  logic          dac_clk_i,
  input  logic          dac_rstn_i,
  input  logic [DW-1:0] ref_i,
  input  logic [DW-1:0] sig_i,
  input  logic          start_i,
  input  logic [NW-1:0] navg_i,
  input  logic [CW-1:0] timeout_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          tout_o,
  output logic          miss_o,
  output logic [CW-1:0] period_sum_o,
  output logic [CW-1:0] delay_sum_o,
  output logic [2:0]    state_o
);
`ifdef ZC_PHASE_HYST_EN
  localparam int LVL = HYST;
`else
  // A zero-width band reduces the detector to plain sign detection.
  localparam int LVL = 0 * HYST;
`endif

  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SYNC = 3'd1, S_MEAS = 3'd2, S_DONE = 3'd3, S_TOUT = 3'd4
  } state_t;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  // ---- crossing detectors (index 0 = ref, 1 = sig), always running ----
  logic [1:0][DW-1:0] smp;
  logic [1:0]         ev;
  logic               ref_ev, sig_ev;

  assign smp = {sig_i, ref_i};

  for (genvar g = 0; g < 2; g++) begin : g_det
    red_pitaya_zc_det #(.DW(DW), .LVL(LVL)) u_det (
      .clk_i  (dac_clk_i),
      .rstn_i (dac_rstn_i),
      .smp_i  (smp[g]),
      .ev_o   (ev[g])
    );
  end

  assign ref_ev = ev[0];
  assign sig_ev = ev[1];

  // ---- state ----
  state_t          state_q, state_d;
  logic [CW-1:0]   pcnt_q, pcnt_d, dcnt_q, dcnt_d, tcnt_q, tcnt_d;
  logic [CW-1:0]   psum_q, psum_d, dsum_q, dsum_d, tmo_q, tmo_d;
  logic [CW-1:0]   psum_o_q, psum_o_d, dsum_o_q, dsum_o_d;
  logic [NW-1:0]   per_q, per_d, navg_q, navg_d;
  logic            pend_q, pend_d, miss_q, miss_d, tout_q, tout_d;

  logic [CW-1:0]   pcnt_inc, dcnt_inc, tcnt_inc;
  logic [NW-1:0]   per_inc;
  logic            tmo_hit;

  always_comb begin
    pcnt_inc = sat_add(pcnt_q, ONE);
    dcnt_inc = sat_add(dcnt_q, ONE);
    tcnt_inc = sat_add(tcnt_q, ONE);
    per_inc  = per_q + NW'(1);
    tmo_hit  = (tmo_q != '0) && (tcnt_inc == tmo_q);
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_SYNC;
      // A ref crossing restarts the timeout window, so it wins over tmo_hit.
      S_SYNC: begin
        if (ref_ev)       state_d = S_MEAS;
        else if (tmo_hit) state_d = S_TOUT;
      end
      S_MEAS: begin
        if (ref_ev) begin
          if (per_inc == navg_q) state_d = S_DONE;
        end else if (tmo_hit) begin
          state_d = S_TOUT;
        end
      end
      S_DONE, S_TOUT: state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // ---- datapath ----
  always_comb begin
    pcnt_d   = pcnt_q;
    dcnt_d   = dcnt_q;
    tcnt_d   = tcnt_q;
    psum_d   = psum_q;
    dsum_d   = dsum_q;
    tmo_d    = tmo_q;
    per_d    = per_q;
    navg_d   = navg_q;
    pend_d   = pend_q;
    miss_d   = miss_q;
    tout_d   = tout_q;
    psum_o_d = psum_o_q;
    dsum_o_d = dsum_o_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          psum_d = '0;
          dsum_d = '0;
          miss_d = 1'b0;
          tout_d = 1'b0;
          tcnt_d = '0;
          per_d  = '0;
          navg_d = (navg_i == '0) ? NW'(1) : navg_i;
          tmo_d  = timeout_i;
        end
      end
      S_SYNC: begin
        tcnt_d = tcnt_inc;
        if (ref_ev) begin
          tcnt_d = '0;
          pcnt_d = ONE;
          dcnt_d = '0;
          // A coincident sig crossing is a zero delay for the first period.
          pend_d = ~sig_ev;
        end
      end
      S_MEAS: begin
        tcnt_d = tcnt_inc;
        pcnt_d = pcnt_inc;
        if (pend_q) dcnt_d = dcnt_inc;
        if (ref_ev) begin
          // Close the ending period first; a still-pending delay counts as
          // the whole period and flags a miss.
          tcnt_d = '0;
          psum_d = sat_add(psum_q, pcnt_q);
          if (pend_q) begin
            dsum_d = sat_add(dsum_q, pcnt_q);
            miss_d = 1'b1;
          end
          pcnt_d = ONE;
          dcnt_d = '0;
          pend_d = ~sig_ev;
          per_d  = per_inc;
        end else if (sig_ev && pend_q) begin
          dsum_d = sat_add(dsum_q, dcnt_inc);
          pend_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Results are published on the same edge that raises done_o.
    if (state_d == S_DONE) begin
      psum_o_d = psum_d;
      dsum_o_d = dsum_d;
    end else if (state_d == S_TOUT) begin
      psum_o_d = '0;
      dsum_o_d = '0;
      tout_d   = 1'b1;
    end
  end

  // ---- FSM: state register and datapath flops ----
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      state_q  <= S_IDLE;
      pcnt_q   <= '0;
      dcnt_q   <= '0;
      tcnt_q   <= '0;
      psum_q   <= '0;
      dsum_q   <= '0;
      tmo_q    <= '0;
      per_q    <= '0;
      navg_q   <= '0;
      pend_q   <= 1'b0;
      miss_q   <= 1'b0;
      tout_q   <= 1'b0;
      psum_o_q <= '0;
      dsum_o_q <= '0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      dcnt_q   <= dcnt_d;
      tcnt_q   <= tcnt_d;
      psum_q   <= psum_d;
      dsum_q   <= dsum_d;
      tmo_q    <= tmo_d;
      per_q    <= per_d;
      navg_q   <= navg_d;
      pend_q   <= pend_d;
      miss_q   <= miss_d;
      tout_q   <= tout_d;
      psum_o_q <= psum_o_d;
      dsum_o_q <= dsum_o_d;
    end
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_SYNC, S_MEAS: busy_o = 1'b1;
      S_DONE, S_TOUT: done_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o      = state_q;
  assign tout_o       = tout_q;
  assign miss_o       = miss_q;
  assign period_sum_o = psum_o_q;
  assign delay_sum_o  = dsum_o_q;
endmodule

// File: tb/tb_red_pitaya_zc_phase_meter.sv
// Directed bench for red_pitaya_zc_phase_meter: table of measurement vectors
// plus hand-written sequences for restart-ignore, hysteresis/noise and reset.
module tb_red_pitaya_zc_phase_meter;
  localparam int DW = 14;
  localparam int CW = 32;
  localparam int NW = 8;
  localparam int LIMIT = 3000;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] ref_i, sig_i;
  logic          start_i;
  logic [NW-1:0] navg_i;
  logic [CW-1:0] timeout_i;
  logic          busy_o, done_o, tout_o, miss_o;
  logic [CW-1:0] period_sum_o, delay_sum_o;
  logic [2:0]    state_o;

  red_pitaya_zc_phase_meter #(.DW(DW), .CW(CW), .NW(NW), .HYST(16)) dut (
    .dac_clk_i    (clk),
    .dac_rstn_i   (rstn),
    .ref_i        (ref_i),
    .sig_i        (sig_i),
    .start_i      (start_i),
    .navg_i       (navg_i),
    .timeout_i    (timeout_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .tout_o       (tout_o),
    .miss_o       (miss_o),
    .period_sum_o (period_sum_o),
    .delay_sum_o  (delay_sum_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Waveform modes: 0 square +-4000, 1 const -500, 2 const +100,
  // 3 period-200 square +-2000 with chatter around the rising crossing.
  int ref_mode = 1, sig_mode = 1, per = 100, lag = 0, t = 0;

  function automatic logic [DW-1:0] wave(input int mode, input int tt, input int p);
    int ph;
    logic [DW-1:0] v;
    v = DW'(0);
    case (mode)
      0: begin
        ph = tt % p;
        v = (ph < p / 2) ? DW'(4000) : DW'(-4000);
      end
      1: v = DW'(-500);
      2: v = DW'(100);
      default: begin
        ph = tt % 200;
        case ((ph + 4) % 200)
          0: v = DW'(-9);
          1: v = DW'(3);
          2: v = DW'(-5);
          3: v = DW'(8);
          4: v = DW'(-4);
          5: v = DW'(6);
          6: v = DW'(-2);
          7: v = DW'(9);
          default: v = (ph < 100) ? DW'(2000) : DW'(-2000);
        endcase
      end
    endcase
    return v;
  endfunction

  initial begin
    ref_i = wave(ref_mode, 0, per);
    sig_i = wave(sig_mode, 0, per);
    forever begin
      @(posedge clk);
      #1;
      t++;
      ref_i = wave(ref_mode, t, per);
      sig_i = wave(sig_mode, t + 4 * per - lag, per);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_meas(input int nav, input int tmo);
    @(posedge clk);
    #1;
    navg_i    = NW'(nav);
    timeout_i = CW'(tmo);
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
  endtask

  // Counts posedges from the call until done_o is seen (sampled at negedge).
  task automatic wait_done(output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (!got && n < LIMIT) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = done_o;
    end
  endtask

  typedef struct {
    int ref_mode; int per; int lag; int sig_mode; int nav; int tmo;
    int exp_ps;   int exp_ds; int exp_miss; int exp_tout; int exp_cyc;
  } vec_t;

  initial begin
    vec_t vt[7];
    int   n, nd;
    bit   got;

    vt[0] = '{0, 100, 25, 0, 4,    0, 400, 100, 0, 0,   -1};
    vt[1] = '{0, 100,  0, 0, 2,    0, 200,   0, 0, 0,   -1};
    vt[2] = '{0, 100,  0, 2, 3,    0, 300, 300, 1, 0,   -1};
    vt[3] = '{0,  50, 10, 0, 0,    0,  50,  10, 0, 0,   -1};
    vt[4] = '{1, 100,  0, 1, 4, 1000,   0,   0, 0, 1, 1000};
    vt[5] = '{0, 100, 99, 0, 1,  150, 100,  99, 0, 0,   -1};
    vt[6] = '{0,  60, 30, 0, 10,   0, 600, 300, 0, 0,   -1};

    rstn = 1'b0; start_i = 1'b0; navg_i = '0; timeout_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset done_o",  64'(done_o), 64'd0);
    chk("reset busy_o",  64'(busy_o), 64'd0);
    chk("reset tout_o",  64'(tout_o), 64'd0);
    chk("reset miss_o",  64'(miss_o), 64'd0);
    chk("reset psum",    64'(period_sum_o), 64'd0);
    chk("reset dsum",    64'(delay_sum_o), 64'd0);
    chk("reset state_o", 64'(state_o), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      ref_mode = vt[i].ref_mode; sig_mode = vt[i].sig_mode;
      per = vt[i].per; lag = vt[i].lag;
      repeat (3 * vt[i].per) @(posedge clk);
      start_meas(vt[i].nav, vt[i].tmo);
      wait_done(n, got);
      chk($sformatf("v%0d done seen", i), 64'(got), 64'd1);
      chk($sformatf("v%0d period_sum", i), 64'(period_sum_o), 64'(vt[i].exp_ps));
      chk($sformatf("v%0d delay_sum", i),  64'(delay_sum_o),  64'(vt[i].exp_ds));
      chk($sformatf("v%0d miss_o", i),     64'(miss_o),       64'(vt[i].exp_miss));
      chk($sformatf("v%0d tout_o", i),     64'(tout_o),       64'(vt[i].exp_tout));
      chk($sformatf("v%0d busy in done", i), 64'(busy_o), 64'd0);
      if (vt[i].exp_cyc >= 0)
        chk($sformatf("v%0d cycles to done", i), 64'(n), 64'(vt[i].exp_cyc));
      @(negedge clk);
      chk($sformatf("v%0d done pulse width", i), 64'(done_o), 64'd0);
      chk($sformatf("v%0d busy after done", i),  64'(busy_o), 64'd0);
      chk($sformatf("v%0d idle state", i),       64'(state_o), 64'd0);
    end

    // Second start while measuring must not restart the measurement.
    ref_mode = 0; sig_mode = 0; per = 100; lag = 25;
    repeat (300) @(posedge clk);
    start_meas(4, 0);
    repeat (150) @(posedge clk);
    @(negedge clk);
    chk("mid busy_o",  64'(busy_o), 64'd1);
    chk("mid state_o", 64'(state_o), 64'd2);
    start_meas(4, 0);
    wait_done(n, got);
    chk("restart done seen", 64'(got), 64'd1);
    checks++;
    if (n >= 380) begin
      errors++;
      $display("FAIL restart_ignored: %0d cycles after second start, required < 380", n);
    end
    chk("restart period_sum", 64'(period_sum_o), 64'd400);
    chk("restart delay_sum",  64'(delay_sum_o),  64'd100);

    // Chatter around the rising crossing: four events per period without the
    // hysteresis band (gaps 2,2,2,194), one event per period with it.
    ref_mode = 3; sig_mode = 3; per = 200; lag = 0;
    repeat (400) @(posedge clk);
    start_meas(8, 0);
    wait_done(n, got);
    chk("noise done seen", 64'(got), 64'd1);
`ifdef ZC_PHASE_HYST_EN
    chk("noise period_sum", 64'(period_sum_o), 64'd1600);
`else
    chk("noise period_sum", 64'(period_sum_o), 64'd400);
`endif

    // Reset in MEAS: everything clears and no completion follows.
    ref_mode = 0; sig_mode = 0; per = 100; lag = 25;
    repeat (300) @(posedge clk);
    start_meas(4, 0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("pre-reset state_o", 64'(state_o), 64'd2);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid-reset state_o", 64'(state_o), 64'd0);
    chk("mid-reset busy_o",  64'(busy_o), 64'd0);
    chk("mid-reset done_o",  64'(done_o), 64'd0);
    chk("mid-reset psum",    64'(period_sum_o), 64'd0);
    chk("mid-reset dsum",    64'(delay_sum_o), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    nd = 0;
    repeat (600) begin
      @(negedge clk);
      if (done_o) nd++;
    end
    chk("no done after reset", 64'(nd), 64'd0);
    chk("idle after reset",    64'(state_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
